// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite from a synchronous ROM into a framebuffer RAM at (x, y).
// Latency: pixel read in cycle k is written in cycle k+2; SPR_W*SPR_H + 3 cycles from start to done.
// Backpressure: none; start is only accepted in IDLE, one pixel per cycle, transparent/off-screen pixels skipped.
module sprite_blitter #(
  parameter int SPR_W       = 30,
  parameter int SPR_H       = 64,
  parameter int IDX_W       = 3,
  parameter int ROM_AW      = 11,
  parameter int FB_W        = 320,
  parameter int FB_H        = 240,
  parameter int FB_AW       = 17,
  parameter int TRANSPARENT = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [9:0]        i_pos_x,
  input  logic [9:0]        i_pos_y,
  input  logic              i_flip_h,
  output logic              o_busy,
  output logic              o_done,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [IDX_W-1:0]  i_rom_q,
  output logic [FB_AW-1:0]  o_fb_addr,
  output logic [IDX_W-1:0]  o_fb_data,
  output logic              o_fb_we
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = $clog2(SPR_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [SX_W-1:0]    r_sx;
  logic [SY_W-1:0]    r_sy;
  logic [9:0]         r_pos_x;
  logic [9:0]         r_pos_y;
  logic               r_flip;
  logic               r_drain_cnt;
  logic               r_busy;
  logic               r_done;
  logic [ROM_AW-1:0]  r_rom_addr;

  // stage 1: destination coordinates of the pixel whose ROM read is in flight
  logic [10:0]        r_fx;
  logic [10:0]        r_fy;
  logic               r_valid1;

  // stage 2: framebuffer write port
  logic [FB_AW-1:0]   r_fb_addr;
  logic [IDX_W-1:0]   r_fb_data;
  logic               r_fb_we;

  logic               w_last_col;
  logic               w_last_row;
  logic [SX_W-1:0]    w_nsx;
  logic [SY_W-1:0]    w_nsy;
  logic [ROM_AW-1:0]  w_col_next;
  logic [ROM_AW-1:0]  w_rom_next;
  logic [ROM_AW-1:0]  w_rom_first;
  logic [10:0]        w_fx;
  logic [10:0]        w_fy;
  logic               w_in_bounds;
  logic [FB_AW-1:0]   w_fb_lin;

  // next scan position and the ROM address it reads (mirrored column when flipped)
  always_comb begin
    w_last_col  = (r_sx == SX_W'(SPR_W - 1));
    w_last_row  = (r_sy == SY_W'(SPR_H - 1));
    w_nsx       = w_last_col ? '0 : r_sx + SX_W'(1);
    w_nsy       = w_last_col ? r_sy + SY_W'(1) : r_sy;
    w_col_next  = r_flip ? (ROM_AW'(SPR_W - 1) - ROM_AW'(w_nsx)) : ROM_AW'(w_nsx);
    w_rom_next  = ROM_AW'(w_nsy) * ROM_AW'(SPR_W) + w_col_next;
    w_rom_first = i_flip_h ? ROM_AW'(SPR_W - 1) : '0;
  end

  // destination coordinates at 11 bits so an off-screen sum never wraps back on-screen
  always_comb begin
    w_fx        = {1'b0, r_pos_x} + 11'(r_sx);
    w_fy        = {1'b0, r_pos_y} + 11'(r_sy);
    w_in_bounds = (w_fx < 11'(FB_W)) && (w_fy < 11'(FB_H));
    // only in-bounds coordinates reach the write port, so truncation here is lossless
    w_fb_lin    = FB_AW'(r_fy) * FB_AW'(FB_W) + FB_AW'(r_fx);
  end

  // control FSM: start latch, scan counters, ROM address, busy/done
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sx        <= '0;
      r_sy        <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_flip      <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rom_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_pos_x    <= i_pos_x;
            r_pos_y    <= i_pos_y;
            r_flip     <= i_flip_h;
            r_sx       <= '0;
            r_sy       <= '0;
            r_rom_addr <= w_rom_first;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sx       <= w_nsx;
          r_sy       <= w_nsy;
          r_rom_addr <= w_rom_next;
          if (w_last_col && w_last_row) begin
            r_drain_cnt <= 1'b0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // two-stage write pipeline aligned with the one-cycle ROM read latency
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fx      <= '0;
      r_fy      <= '0;
      r_valid1  <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_fb_we   <= 1'b0;
    end else begin
      r_fx     <= w_fx;
      r_fy     <= w_fy;
      r_valid1 <= (r_state == S_RUN) && w_in_bounds;
      r_fb_we  <= r_valid1 && (i_rom_q != IDX_W'(TRANSPARENT));
      if (r_valid1) begin
        r_fb_addr <= w_fb_lin;
        r_fb_data <= i_rom_q;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rom_addr = r_rom_addr;
  assign o_fb_addr  = r_fb_addr;
  assign o_fb_data  = r_fb_data;
  assign o_fb_we    = r_fb_we;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized scoreboard bench for sprite_blitter with a framebuffer-write reference model.
// Expected writes, done pulses and busy windows are queued at issue time; a negedge monitor checks them.
// Directed scenarios cover clipping, flip, back-to-back starts, mid-blit reset and reset-vs-start.
module tb_sprite_blitter;

  localparam int SW = 30;
  localparam int SH = 64;
  localparam int N  = SW * SH;
  localparam int FW = 320;
  localparam int FH = 240;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_flip_h;
  logic [9:0]  i_pos_x, i_pos_y;
  logic        o_busy, o_done, o_fb_we;
  logic [10:0] o_rom_addr;
  logic [2:0]  rom_q;
  logic [16:0] o_fb_addr;
  logic [2:0]  o_fb_data;

  logic [2:0]  rom [0:N-1];

  typedef struct {int addr; int data; int at;} wr_t;
  wr_t wq[$];
  int  dq[$];

  int edge_no  = 0;
  int b_lo     = 1;
  int b_hi     = 0;
  int compared = 0;
  int failed   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  sprite_blitter dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_pos_x(i_pos_x), .i_pos_y(i_pos_y), .i_flip_h(i_flip_h),
    .o_busy(o_busy), .o_done(o_done), .o_rom_addr(o_rom_addr),
    .i_rom_q(rom_q), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
    .o_fb_we(o_fb_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // synchronous sprite ROM
  always @(posedge clk) rom_q <= (o_rom_addr < 11'(N)) ? rom[o_rom_addr] : 3'd0;

  // monitor: busy window, expected writes (value and cycle), expected done pulses
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy;
      exp_busy = (edge_no >= b_lo) && (edge_no <= b_hi);
      compared++;
      if (o_busy !== exp_busy) begin
        failed++;
        $display("FAIL busy @edge %0d: got %0b want %0b", edge_no, o_busy, exp_busy);
      end
      if (o_fb_we === 1'b1) begin
        wr_cnt++;
        compared++;
        if (wq.size() == 0) begin
          failed++;
          $display("FAIL unexpected_write @edge %0d: addr %0d data %0d", edge_no, o_fb_addr, o_fb_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (int'(o_fb_addr) != e.addr || int'(o_fb_data) != e.data || edge_no != e.at) begin
            failed++;
            $display("FAIL write: got addr %0d data %0d @edge %0d want addr %0d data %0d @edge %0d",
                     o_fb_addr, o_fb_data, edge_no, e.addr, e.data, e.at);
          end
        end
      end else if (wq.size() > 0 && wq[0].at <= edge_no) begin
        wr_t e;
        e = wq.pop_front();
        compared++;
        failed++;
        $display("FAIL missed_write @edge %0d: want addr %0d data %0d", edge_no, e.addr, e.data);
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        compared++;
        if (dq.size() == 0) begin
          failed++;
          $display("FAIL unexpected_done @edge %0d", edge_no);
        end else begin
          int d;
          d = dq.pop_front();
          if (d != edge_no) begin
            failed++;
            $display("FAIL done_time: got edge %0d want edge %0d", edge_no, d);
          end
        end
      end else if (dq.size() > 0 && dq[0] <= edge_no) begin
        int d;
        d = dq.pop_front();
        compared++;
        failed++;
        $display("FAIL missed_done: want edge %0d, done low", d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // mode 0: a mod 8, 1: a mod 7 + 1, 2: all zero, 3: random
  task automatic fill_rom(input int mode);
    for (int a = 0; a < N; a++) begin
      case (mode)
        0: rom[a] = 3'(a % 8);
        1: rom[a] = 3'(a % 7 + 1);
        2: rom[a] = 3'd0;
        default: rom[a] = 3'($urandom_range(0, 7));
      endcase
    end
  endtask

  // reference model: a blit whose start is sampled on the coming edge
  task automatic expect_blit(input int px, input int py, input bit fl);
    int s;
    s = edge_no + 1;
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) begin
        int fx, fy, d;
        fx = px + x;
        fy = py + y;
        d  = int'(rom[y * SW + (fl ? SW - 1 - x : x)]);
        if (fx < FW && fy < FH && d != 0)
          wq.push_back('{addr: fy * FW + fx, data: d, at: s + y * SW + x + 2});
      end
    end
    dq.push_back(s + N + 2);
    b_lo = s;
    b_hi = s + N + 1;
  endtask

  task automatic issue(input int px, input int py, input bit fl);
    i_pos_x  = 10'(px);
    i_pos_y  = 10'(py);
    i_flip_h = fl;
    i_start  = 1'b1;
    expect_blit(px, py, fl);
    step();
    i_start  = 1'b0;
    // later changes must not affect the running blit
    i_pos_x  = 10'($urandom_range(0, 1023));
    i_pos_y  = 10'($urandom_range(0, 1023));
    i_flip_h = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (wq.size() == 0 && dq.size() == 0 && edge_no > b_hi + 1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    compared++;
    if (!ok) begin
      failed++;
      $display("FAIL wait_idle: timed out, %0d writes and %0d dones outstanding", wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
  endtask

  initial begin
    int w0, d0, s, nxt;
    i_reset  = 1'b1;
    i_start  = 1'b0;
    i_pos_x  = '0;
    i_pos_y  = '0;
    i_flip_h = 1'b0;
    fill_rom(2);
    repeat (3) step();

    check("rst_busy",     int'(o_busy),     0);
    check("rst_done",     int'(o_done),     0);
    check("rst_fb_we",    int'(o_fb_we),    0);
    check("rst_rom_addr", int'(o_rom_addr), 0);
    check("rst_fb_addr",  int'(o_fb_addr),  0);
    check("rst_fb_data",  int'(o_fb_data),  0);
    i_reset = 1'b0;
    mon_en  = 1'b1;

    // plain blit at origin
    fill_rom(0);
    w0 = wr_cnt;
    issue(0, 0, 0);
    wait_idle();
    check("s1_write_count", wr_cnt - w0, 1680);

    // clipped at the bottom-right corner
    issue(300, 200, 0);
    wait_idle();

    // horizontal flip
    fill_rom(1);
    issue(10, 5, 1);
    wait_idle();

    // entirely off-screen to the right: no writes, done still pulses
    w0 = wr_cnt;
    d0 = done_cnt;
    issue(400, 10, 0);
    wait_idle();
    check("offscreen_writes", wr_cnt - w0, 0);
    check("offscreen_done",   done_cnt - d0, 1);

    // start held high with pos_x toggling every cycle
    fill_rom(3);
    d0 = done_cnt;
    i_start  = 1'b1;
    i_pos_y  = 10'd100;
    i_flip_h = 1'b0;
    nxt = edge_no + 1;
    for (int c = 0; c < 5000; c++) begin
      i_pos_x = (c % 2 == 0) ? 10'd0 : 10'd305;
      if (edge_no + 1 == nxt) begin
        expect_blit(int'(i_pos_x), 100, 1'b0);
        nxt = nxt + N + 4;
      end
      step();
    end
    i_start = 1'b0;
    check("held_done_count", done_cnt - d0, 2);
    wait_idle();

    // reset in the middle of a blit, then a fresh blit
    fill_rom(0);
    d0 = done_cnt;
    s  = edge_no + 1;
    issue(20, 30, 0);
    while (edge_no < s + 499) step();
    i_reset = 1'b1;
    step();
    wq.delete();
    dq.delete();
    b_lo = 1;
    b_hi = 0;
    i_reset = 1'b0;
    check("midrst_busy",  int'(o_busy),  0);
    check("midrst_fb_we", int'(o_fb_we), 0);
    while (edge_no < s + 509) step();
    check("midrst_no_done", done_cnt - d0, 0);
    issue(50, 60, 1);
    wait_idle();

    // all-zero ROM: timing unchanged, no writes
    fill_rom(2);
    w0 = wr_cnt;
    issue(0, 0, 0);
    wait_idle();
    check("zero_rom_writes", wr_cnt - w0, 0);

    // reset and start together: reset wins
    i_reset = 1'b1;
    i_start = 1'b1;
    step();
    i_reset = 1'b0;
    i_start = 1'b0;
    check("rst_vs_start_busy", int'(o_busy), 0);
    step();
    check("rst_vs_start_busy2", int'(o_busy), 0);

    // randomized blits
    for (int r = 0; r < 4; r++) begin
      fill_rom(3);
      issue(int'($urandom_range(0, 400)), int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer-side counterpart of the sprite ROM/palette display path.
- Copies one SPR_W x SPR_H palette-indexed sprite from a synchronous sprite ROM into a palette-indexed framebuffer RAM at a requested (x, y) position.
- Skips transparent pixels, clips at the framebuffer edges, and supports horizontal flip (facing direction).
- Driven by game logic through a start/busy/done handshake; the framebuffer is later scanned out through the palette by the display path.

Parameters:
- SPR_W, 30, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- IDX_W, 3, palette index width
- ROM_AW, 11, sprite ROM address width; must hold SPR_W*SPR_H-1
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- FB_AW, 17, framebuffer address width; must hold FB_W*FB_H-1
- TRANSPARENT, 0, palette index that is never written

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request a blit; sampled only in IDLE
- pos_x  in  10  framebuffer x of sprite top-left; latched on accepted start
- pos_y  in  10  framebuffer y of sprite top-left; latched on accepted start
- flip_h  in  1  mirror sprite horizontally; latched on accepted start
- busy  out  1  blit in progress
- done  out  1  one-cycle completion pulse
- rom_addr  out  ROM_AW  sprite ROM read address
- rom_q  in  IDX_W  sprite ROM data; valid one cycle after rom_addr
- fb_addr  out  FB_AW  framebuffer write address
- fb_data  out  IDX_W  framebuffer write data (palette index)
- fb_we  out  1  framebuffer write enable

Behaviour:
- Reset: state IDLE; busy, done, fb_we = 0; rom_addr, fb_addr, fb_data = 0. All outputs are registered or driven straight from registers.
- States:
  - IDLE: start=1 latches pos_x, pos_y, flip_h, clears sx and sy, and moves to RUN.
  - RUN: N = SPR_W*SPR_H cycles. sx counts 0..SPR_W-1; on wrap, sx returns to 0 and sy increments. Leaves for DRAIN after the cycle with sx=SPR_W-1, sy=SPR_H-1.
  - DRAIN: exactly 2 cycles, to flush the pipeline.
  - DONE: exactly 1 cycle with done=1, then back to IDLE.
- start outside IDLE is ignored. Changes to pos_x, pos_y or flip_h during a blit have no effect.
- Timing: start is sampled at edge 0.
  - busy=1 in cycles 1..N+2.
  - done=1 in cycle N+3 only; busy=0 in that cycle.
  - Earliest next accepted start is sampled in cycle N+4 (IDLE).
  - Holding start high continuously gives back-to-back blits with one DONE cycle and one IDLE cycle between them.
- Read address: in RUN cycle with counters (sx, sy), rom_addr = sy*SPR_W + (flip_h ? SPR_W-1-sx : sx).
- Pipeline stage 1, registered in the same cycle as the read:
  - fx = pos_x + sx and fy = pos_y + sy, computed at 11 bits so there is no wrap.
  - valid1 = RUN && fx < FB_W && fy < FB_H.
- Pipeline stage 2, registered on the next cycle:
  - fb_we = valid1 && (rom_q != TRANSPARENT).
  - fb_addr = fy*FB_W + fx, truncated to FB_AW only after the bounds check.
  - fb_data = rom_q.
- A pixel read in cycle k is written in cycle k+2. Throughput is one pixel per cycle. Writes occur in row-major order.
- Outside RUN and DRAIN, fb_we = 0. fb_addr and fb_data hold their last values.
- Clipping:
  - Pixels with fx ≥ FB_W or fy ≥ FB_H produce no write; the blit still takes N cycles.
  - pos_x ≥ FB_W produces zero writes but still completes normally with done.
- Reset mid-blit:
  - Next cycle: IDLE, busy=0, fb_we=0.
  - No further writes; no done pulse.
  - The next start behaves normally.
- Reset and start asserted in the same cycle: reset wins.

Test Plan:
- ROM[a] = a mod 8, pos (0,0), no flip, start pulse at edge 0:
  - busy high for cycles 1..1922, done only in cycle 1923.
  - 1680 writes (indices 1..7 only).
  - First write has fb_addr=1, fb_data=1 (pixel 0 is transparent, skipped).
  - Row 1 first write has fb_addr=320.
- Same ROM, pos (300,200):
  - Only sx<20, sy<40 can be written; nonzero writes among those 800 pixels.
  - No fb_addr ≥ 76800, no write with x<300.
  - done still pulses in cycle 1923.
- flip_h=1, pos (10,5), ROM[a] = a mod 7 + 1:
  - Write at fb_addr 5*320+10 = 1610 carries ROM[29] = 2.
  - Write at fb_addr 1610+29 carries ROM[0] = 1.
- start held high for 5000 cycles, pos_x toggled every cycle:
  - Exactly 2 done pulses, in cycles 1923 and 3847.
  - Each blit uses the pos_x latched at its accepted start.
- Reset asserted in cycle 500 of a blit:
  - Cycle 501: busy=0, fb_we=0.
  - No done pulse.
  - A new start in cycle 510 completes with done in cycle 2433.
- All-zero ROM:
  - fb_we never asserts.
  - busy/done timing identical to scenario 1.
